wbs_uart_tx: RTL and testbench

Wishbone B4 pipelined UART transmitter peripheral, one slot downstream of the single-master interconnect. It takes that slot's `wbs_cyc_i` bit plus the shared strobe, address, select and data lines, and buffers written bytes in a small FIFO. It serialises them 8N1, LSB first, on `uart_tx_o`, and exposes status and baud-divisor registers on the 4-bit slave address space.

---
 rtl/wb_pkg.sv | 32 +++
 rtl/fifo_sync.sv | 55 +++++
 rtl/wbs_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_wbs_uart_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone peripherals: register map, status layout,
// clock constants and the UART transmitter state encoding.
package wb_pkg;

  localparam int unsigned CPU_CLK_HZ = 48_000_000;
  localparam int unsigned UART_BAUD  = 115_200;
  // Rounded to nearest so the bit period error stays under half a clock.
  localparam int unsigned CLK_DIV_115200 = (CPU_CLK_HZ + UART_BAUD / 2) / UART_BAUD;

  localparam logic [3:0] UART_TX_DATA   = 4'h0;
  localparam logic [3:0] UART_TX_STATUS = 4'h1;
  localparam logic [3:0] UART_TX_DIV    = 4'h2;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_LEVEL_LSB = 8;

  localparam logic [15:0] UART_DIV_MIN = 16'd4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < UART_DIV_MIN) ? UART_DIV_MIN : value;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with show-ahead read data, simultaneous push/pop and
// an occupancy count; shared by the Wishbone peripherals.
module fifo_sync #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      pop_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  do_push, do_pop;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == FULL_LEVEL);
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_pop     = pop_i && !empty_o;
  // A push into a full FIFO is only safe when the same edge frees a slot.
  assign do_push    = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   level_q <= level_q - (DEPTH_LOG2 + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/wbs_uart_tx.sv
// Wishbone B4 pipelined UART transmitter: byte FIFO feeding an 8N1 serialiser,
// with DATA / STATUS / DIVISOR registers on a 4-bit word address space.
module wbs_uart_tx
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int CLK_DIV_RESET   = CLK_DIV_115200
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_adr_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_stall_o,
  output logic        wbs_ack_o,
  output logic        uart_tx_o
);

  localparam logic [15:0] DIV_RESET = 16'(CLK_DIV_RESET);

  logic                     fifo_full, fifo_empty;
  logic [FIFO_DEPTH_LOG2:0] fifo_level;
  logic [7:0]               fifo_data;
  logic                     req, accept, push, pop;
  logic [31:0]              rdata;
  logic [15:0]              div_q, div_d;
  logic                     ack_q;
  logic [31:0]              dat_q;
  tx_state_e                state_q;
  logic [7:0]               shift_q;
  logic [2:0]               bit_q;
  logic [15:0]              baud_q, div_lat_q;
  logic                     tx_q;
  logic                     unused_bits;

  assign req         = wbs_cyc_i && wbs_stb_i;
  assign wbs_stall_o = req && wbs_we_i && (wbs_adr_i == UART_TX_DATA) && fifo_full;
  assign accept      = req && !wbs_stall_o;
  assign push        = accept && wbs_we_i && (wbs_adr_i == UART_TX_DATA) && wbs_sel_i[0];
  // Pop when leaving IDLE, or on the last STOP cycle so frames chain with no gap.
  assign pop         = !fifo_empty &&
                       ((state_q == TX_IDLE) || (state_q == TX_STOP && baud_q == 16'd0));
  assign div_d       = clamp_div({wbs_sel_i[1] ? wbs_dat_i[15:8] : div_q[15:8],
                                  wbs_sel_i[0] ? wbs_dat_i[7:0]  : div_q[7:0]});
  assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};

  fifo_sync #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i       (wb_clk_i),
    .srst_i      (wb_rst_i),
    .push_i      (push),
    .push_data_i (wbs_dat_i[7:0]),
    .pop_i       (pop),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  always_comb begin
    rdata = '0;
    case (wbs_adr_i)
      UART_TX_STATUS: begin
        rdata[STATUS_EMPTY_BIT] = fifo_empty;
        rdata[STATUS_FULL_BIT]  = fifo_full;
        rdata[STATUS_BUSY_BIT]  = (state_q != TX_IDLE);
        rdata[STATUS_LEVEL_LSB +: FIFO_DEPTH_LOG2 + 1] = fifo_level;
      end
      UART_TX_DIV: rdata[15:0] = div_q;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      div_q <= DIV_RESET;
    end else begin
      ack_q <= accept;
      dat_q <= (accept && !wbs_we_i) ? rdata : '0;
      if (accept && wbs_we_i && wbs_adr_i == UART_TX_DIV) begin
        div_q <= div_d;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= TX_IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_q     <= '0;
      baud_q    <= '0;
      div_lat_q <= DIV_RESET;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q   <= fifo_data;
            div_lat_q <= div_q;
            baud_q    <= div_q - 16'd1;
            tx_q      <= 1'b0;
            state_q   <= TX_START;
          end
        end
        TX_START: begin
          if (baud_q == 16'd0) begin
            tx_q    <= shift_q[0];
            bit_q   <= '0;
            baud_q  <= div_lat_q - 16'd1;
            state_q <= TX_DATA;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (baud_q == 16'd0) begin
            baud_q <= div_lat_q - 16'd1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              tx_q    <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        TX_STOP: begin
          if (baud_q != 16'd0) begin
            baud_q <= baud_q - 16'd1;
          end else if (pop) begin
            shift_q   <= fifo_data;
            div_lat_q <= div_q;
            baud_q    <= div_q - 16'd1;
            tx_q      <= 1'b0;
            state_q   <= TX_START;
          end else begin
            state_q <= TX_IDLE;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign uart_tx_o = tx_q;

endmodule

// File: tb/tb_wbs_uart_tx.sv
// Self-checking bench for wbs_uart_tx: register vector table, hand-written
// timing sequences and randomized traffic against a frame-level line model.
module tb_wbs_uart_tx;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  adr = '0, sel = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        stall, ack, tx;

  wbs_uart_tx dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_adr_i   (adr),
    .wbs_sel_i   (sel),
    .wbs_dat_i   (dat_i),
    .wbs_dat_o   (dat_o),
    .wbs_stall_o (stall),
    .wbs_ack_o   (ack),
    .uart_tx_o   (tx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int ack_seen = 0;
  int acc_cnt = 0;
  int last_acc = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) if (ack === 1'b1) ack_seen <= ack_seen + 1;

  // Line model: each expected frame is a byte plus the divisor in force when it starts.
  typedef struct {
    logic [7:0] b;
    int         div;
  } frame_t;

  frame_t exp_q[$];
  int     starts[$];
  int     frames_done = 0;
  bit     mon_en = 1'b0;
  bit     mon_abort = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc_cnt);
    end
  endtask

  function automatic int start_at(input int k);
    return (k < starts.size()) ? starts[k] : -1;
  endfunction

  initial begin : monitor
    frame_t     e;
    logic [9:0] bits;
    int         bad;
    forever begin
      @(negedge clk);
      if (mon_en && !mon_abort && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, nothing queued", cyc_cnt);
          while (tx !== 1'b1 && !mon_abort) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          starts.push_back(cyc_cnt);
          bits = {1'b1, e.b, 1'b0};
          bad = 0;
          for (int n = 0; n < 10 * e.div; n++) begin
            if (n != 0) @(negedge clk);
            if (mon_abort) break;
            if (tx !== bits[n / e.div]) bad++;
          end
          if (!mon_abort) begin
            n_cmp++;
            if (bad != 0) begin
              n_err++;
              $display("FAIL frame: byte 0x%02h div %0d had %0d wrong line samples, required 0",
                       e.b, e.div, bad);
            end
            frames_done++;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One classic request; returns at posedge+1 of the cycle carrying its ack.
  task automatic xfer(input logic w, input logic [3:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rd, output int stalls);
    logic st;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    stalls = 0;
    rd = '0;
    while (1) begin
      @(negedge clk);
      st = stall;
      @(posedge clk);
      #1;
      if (st === 1'b0) break;
      stalls++;
      if (stalls >= 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL stall_timeout: adr 0x%0h still stalled after %0d cycles, required accept", a, stalls);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        return;
      end
    end
    last_acc = cyc_cnt;
    acc_cnt++;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack", {31'd0, ack}, 32'd1);
    rd = dat_o;
    if (w) chk("wr_dat_o", dat_o, 32'd0);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (frames_done < target && t < budget);
    #1;
    chk("frames_done", frames_done, target);
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] req;
    string       name;
  } vec_t;

  vec_t vt[16];

  initial begin : watchdog
    #900_000;
    n_err++;
    $display("FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc_cnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : main
    logic [31:0] rd, tmp;
    int          stl;
    int          a0, s0, fd0, pushed, mdiv, dv, op;
    logic [7:0]  b, bytes[6];
    logic [3:0]  s, a;
    int          acc[6], stc[6];
    int          i, guard;
    logic        st;

    vt[0]  = '{1'b0, UART_TX_DIV,    4'hF, 32'h0,        32'h1A1, "div_reset"};
    vt[1]  = '{1'b0, UART_TX_STATUS, 4'hF, 32'h0,        32'h1,   "status_reset"};
    vt[2]  = '{1'b0, 4'h3,           4'hF, 32'h0,        32'h0,   "rd_unmapped"};
    vt[3]  = '{1'b1, UART_TX_DIV,    4'h3, 32'h1,        32'h0,   "wr_div_1"};
    vt[4]  = '{1'b0, UART_TX_DIV,    4'hF, 32'h0,        32'h4,   "div_clamp"};
    vt[5]  = '{1'b1, UART_TX_DIV,    4'h2, 32'h0300,     32'h0,   "wr_div_hi"};
    vt[6]  = '{1'b0, UART_TX_DIV,    4'hF, 32'h0,        32'h304, "div_hi_lane"};
    vt[7]  = '{1'b1, UART_TX_DIV,    4'h1, 32'h55AA00FF, 32'h0,   "wr_div_lo"};
    vt[8]  = '{1'b0, UART_TX_DIV,    4'hF, 32'h0,        32'h3FF, "div_lo_lane"};
    vt[9]  = '{1'b1, UART_TX_DIV,    4'hF, 32'hFFFF0002, 32'h0,   "wr_div_2"};
    vt[10] = '{1'b0, UART_TX_DIV,    4'hF, 32'h0,        32'h4,   "div_clamp2"};
    vt[11] = '{1'b1, 4'h7,           4'hF, 32'h12345678, 32'h0,   "wr_unmapped"};
    vt[12] = '{1'b0, UART_TX_DIV,    4'hF, 32'h0,        32'h4,   "div_after_ignored"};
    vt[13] = '{1'b1, UART_TX_DATA,   4'hE, 32'h5A,       32'h0,   "data_nosel"};
    vt[14] = '{1'b0, UART_TX_STATUS, 4'hF, 32'h0,        32'h1,   "status_no_push"};
    vt[15] = '{1'b0, UART_TX_DATA,   4'hF, 32'h0,        32'h0,   "rd_data"};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat_o", dat_o, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    mon_en = 1'b1;

    // Register vector table
    foreach (vt[k]) begin
      xfer(vt[k].w, vt[k].a, vt[k].s, vt[k].d, rd, stl);
      chk(vt[k].name, rd, vt[k].req);
      $display("vec %0d %s we=%0b adr=0x%0h dat_o=0x%08h", k, vt[k].name, vt[k].w, vt[k].a, rd);
    end

    // Single frame at div 4
    starts.delete();
    fd0 = frames_done;
    exp_q.push_back('{b: 8'hA5, div: 4});
    xfer(1'b1, UART_TX_DATA, 4'h1, 32'hA5, rd, stl);
    a0 = last_acc;
    xfer(1'b0, UART_TX_STATUS, 4'hF, 0, rd, stl);
    chk("status_after_push", rd, 32'h100);
    xfer(1'b0, UART_TX_STATUS, 4'hF, 0, rd, stl);
    chk("status_busy", rd, 32'h5);
    wait_frames(fd0 + 1, 100);
    chk("tx_fall_latency", start_at(0), a0 + 1);
    xfer(1'b0, UART_TX_STATUS, 4'hF, 0, rd, stl);
    chk("status_idle_after", rd, 32'h1);
    $display("single frame 0xA5 start cycle %0d", start_at(0));

    // Six back-to-back DATA writes
    starts.delete();
    fd0 = frames_done;
    for (int k = 0; k < 6; k++) begin
      tmp = $urandom();
      bytes[k] = tmp[7:0];
      exp_q.push_back('{b: tmp[7:0], div: 4});
      stc[k] = 0;
      acc[k] = 0;
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = UART_TX_DATA; sel = 4'h1;
    i = 0;
    guard = 0;
    while (i < 6 && guard < 300) begin
      dat_i = {24'h0, bytes[i]};
      @(negedge clk);
      st = stall;
      @(posedge clk);
      #1;
      guard++;
      if (st === 1'b0) begin
        acc[i] = cyc_cnt;
        i++;
      end else begin
        stc[i]++;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    acc_cnt += i;
    chk("burst_accepted", i, 6);
    for (int k = 0; k < 5; k++) chk("burst_no_stall", stc[k], 0);
    chk("burst_6th_accept", acc[5] - acc[0], 42);
    wait_frames(fd0 + 6, 400);
    chk("burst_first_start", start_at(0), acc[0] + 1);
    for (int k = 1; k < 6; k++) chk("gapless", start_at(k) - start_at(0), 40 * k);
    $display("burst: six frames, sixth write stalled %0d cycles", stc[5]);

    // Divisor change mid-frame
    starts.delete();
    fd0 = frames_done;
    exp_q.push_back('{b: 8'h3C, div: 4});
    exp_q.push_back('{b: 8'hC1, div: 8});
    xfer(1'b1, UART_TX_DATA, 4'h1, 32'h3C, rd, stl);
    s0 = last_acc + 1;
    xfer(1'b1, UART_TX_DATA, 4'h1, 32'hC1, rd, stl);
    while (cyc_cnt < s0 + 8) begin
      @(posedge clk);
      #1;
    end
    xfer(1'b1, UART_TX_DIV, 4'h3, 32'h8, rd, stl);
    wait_frames(fd0 + 2, 300);
    chk("div_change_gap", start_at(1) - start_at(0), 40);
    xfer(1'b0, UART_TX_DIV, 4'hF, 0, rd, stl);
    chk("div_readback_8", rd, 32'h8);
    xfer(1'b1, UART_TX_DIV, 4'h3, 32'h4, rd, stl);
    $display("div change: frames started at %0d and %0d", start_at(0), start_at(1));

    // Reset mid-DATA with three bytes queued
    starts.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back('{b: 8'(8'h10 + k), div: 4});
    xfer(1'b1, UART_TX_DATA, 4'h1, 32'h10, rd, stl);
    s0 = last_acc + 1;
    for (int k = 1; k < 4; k++) xfer(1'b1, UART_TX_DATA, 4'h1, 32'h10 + k, rd, stl);
    while (cyc_cnt < s0 + 11) begin
      @(posedge clk);
      #1;
    end
    mon_abort = 1'b1;
    rst = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = UART_TX_DIV; sel = 4'h3; dat_i = 32'h10;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    chk("rst_mid_ack", {31'd0, ack}, 32'd0);
    idle(1);
    chk("rst_req_dropped", {31'd0, ack}, 32'd0);
    exp_q.delete();
    fd0 = frames_done;
    xfer(1'b0, UART_TX_STATUS, 4'hF, 0, rd, stl);
    chk("status_after_rst", rd, 32'h1);
    xfer(1'b0, UART_TX_DIV, 4'hF, 0, rd, stl);
    chk("div_after_rst", rd, 32'h1A1);
    mon_abort = 1'b0;
    idle(60);
    chk("no_frames_after_rst", frames_done, fd0);
    $display("mid-frame reset: line and status returned to idle");

    // Randomized traffic, one divisor per round
    for (int r = 0; r < 3; r++) begin
      dv = $urandom_range(0, 9);
      tmp = $urandom();
      mdiv = (dv < 4) ? 4 : dv;
      xfer(1'b1, UART_TX_DIV, 4'h3, {tmp[31:16], 8'h00, 8'(dv)}, rd, stl);
      fd0 = frames_done;
      pushed = 0;
      for (int k = 0; k < 25; k++) begin
        op = $urandom_range(0, 9);
        if (op < 7) begin
          b = 8'($urandom_range(0, 255));
          s = 4'($urandom_range(0, 15));
          if (s[0]) begin
            exp_q.push_back('{b: b, div: mdiv});
            pushed++;
          end
          xfer(1'b1, UART_TX_DATA, s, {24'h0, b}, rd, stl);
          $display("rnd r%0d wr DATA 0x%02h sel 0x%0h stalled %0d", r, b, s, stl);
        end else if (op < 9) begin
          xfer(1'b0, UART_TX_DIV, 4'hF, 0, rd, stl);
          chk("rnd_div", rd, mdiv);
          $display("rnd r%0d rd DIV 0x%08h", r, rd);
        end else begin
          a = 4'($urandom_range(3, 15));
          xfer(1'b0, a, 4'hF, 0, rd, stl);
          chk("rnd_unmapped", rd, 32'h0);
          $display("rnd r%0d rd 0x%0h 0x%08h", r, a, rd);
        end
        idle($urandom_range(0, 40));
      end
      wait_frames(fd0 + pushed, pushed * 10 * mdiv + 200);
    end

    idle(3);
    chk("ack_count", ack_seen, acc_cnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
